// File: rtl/exp_range_reduce_if.sv
// rtl/exp_range_reduce_if.sv - request/response bus between the system and exp_range_reduce
interface exp_range_reduce_if #(
  parameter int INT_W  = 3,
  parameter int FRAC_W = 16,
  parameter int OUT_W  = 28
);
  logic                    start;
  logic [INT_W+FRAC_W-1:0] xIn;
  logic                    busy;
  logic                    done;
  logic [OUT_W-1:0]        yOut;
  logic                    err;

  modport master (output start, xIn, input busy, done, yOut, err);
  modport slave  (input start, xIn, output busy, done, yOut, err);
endinterface

// File: rtl/exp_range_reduce.sv
// rtl/exp_range_reduce.sv - e^x range reduction around the expTop core: e^x = e^n * e^f
// Optional core-wait timeout is built in when EXP_RR_TIMEOUT_EN is defined.
module exp_range_reduce #(
  parameter int FRAC_W = 16,
  parameter int INT_W  = 3,
  parameter int OUT_W  = 28
`ifdef EXP_RR_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  exp_range_reduce_if.slave sys,
  output logic              coreRst,
  output logic              coreStart,
  output logic [FRAC_W-1:0] coreX,
  input  logic [FRAC_W+1:0] coreR,
  input  logic              coreDone
);
  localparam int R_W   = FRAC_W + 2;
  localparam int ACC_W = R_W + OUT_W;
  localparam int RND_W = ACC_W - FRAC_W;
  localparam int I_W   = $clog2(R_W);
  localparam logic [I_W-1:0] I_LAST = I_W'(R_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_CRST, S_LAUNCH, S_WAIT, S_MUL, S_DONE} state_t;

  state_t             state, state_d;
  logic [INT_W-1:0]   n_q;
  logic [FRAC_W-1:0]  f_q;
  logic [R_W-1:0]     r_q;
  logic [ACC_W-1:0]   acc_q, acc_d, addend;
  logic [I_W-1:0]     i_q;
  logic [OUT_W-1:0]   y_q, y_d, e_n;
  logic [RND_W-1:0]   rnd;
  logic               busy_c, done_c, start_c, rst_c;
  logic               tmo_hit;

  // round(e^n * 2^16) for n = 0..7
  function automatic logic [OUT_W-1:0] exp_rom(input logic [INT_W-1:0] k);
    case (int'(k))
      0:       exp_rom = OUT_W'(65536);
      1:       exp_rom = OUT_W'(178145);
      2:       exp_rom = OUT_W'(484249);
      3:       exp_rom = OUT_W'(1316326);
      4:       exp_rom = OUT_W'(3578144);
      5:       exp_rom = OUT_W'(9726405);
      6:       exp_rom = OUT_W'(26439109);
      7:       exp_rom = OUT_W'(71868951);
      default: exp_rom = '0;
    endcase
  endfunction

  assign e_n    = exp_rom(n_q);
  assign addend = r_q[i_q] ? (ACC_W'(e_n) << i_q) : '0;
  assign acc_d  = acc_q + addend;
  // Adding the first dropped bit gives round-half-up of acc / 2^16
  assign rnd    = acc_d[ACC_W-1:FRAC_W] + RND_W'(acc_d[FRAC_W-1]);
  assign y_d    = (|rnd[RND_W-1:OUT_W]) ? '1 : rnd[OUT_W-1:0];

`ifdef EXP_RR_TIMEOUT_EN
  logic [7:0] tmo_q;
  logic       err_q;
  assign tmo_hit = (tmo_q == 8'(TIMEOUT - 1));
  assign sys.err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign sys.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    busy_c  = (state != S_IDLE);
    done_c  = 1'b0;
    start_c = 1'b0;
    rst_c   = !rst;
    case (state)
      S_IDLE:   if (sys.start) state_d = S_CRST;
      S_CRST:   begin rst_c = 1'b1; state_d = S_LAUNCH; end
      S_LAUNCH: begin start_c = 1'b1; state_d = S_WAIT; end
      S_WAIT: begin
        if (coreDone)     state_d = S_MUL;
        else if (tmo_hit) state_d = S_DONE;
      end
      S_MUL:    if (i_q == I_LAST) state_d = S_DONE;
      S_DONE:   begin done_c = 1'b1; state_d = S_IDLE; end
      default:  state_d = S_IDLE;
    endcase
  end

  assign sys.busy  = busy_c;
  assign sys.done  = done_c;
  assign sys.yOut  = y_q;
  assign coreStart = start_c;
  assign coreRst   = rst_c;
  assign coreX     = f_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q   <= '0;
      f_q   <= '0;
      r_q   <= '0;
      acc_q <= '0;
      i_q   <= '0;
      y_q   <= '0;
`ifdef EXP_RR_TIMEOUT_EN
      tmo_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (sys.start) begin
          n_q <= sys.xIn[FRAC_W +: INT_W];
          f_q <= sys.xIn[FRAC_W-1:0];
`ifdef EXP_RR_TIMEOUT_EN
          err_q <= 1'b0;
`endif
        end
`ifdef EXP_RR_TIMEOUT_EN
        S_LAUNCH: tmo_q <= '0;
`endif
        S_WAIT: begin
          if (coreDone) begin
            r_q   <= coreR;
            acc_q <= '0;
            i_q   <= '0;
          end
`ifdef EXP_RR_TIMEOUT_EN
          else if (tmo_hit) begin
            err_q <= 1'b1;
            y_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        S_MUL: begin
          acc_q <= acc_d;
          i_q   <= i_q + I_W'(1);
          if (i_q == I_LAST) y_q <= y_d;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exp_range_reduce.sv
// tb/tb_exp_range_reduce.sv - scoreboard bench for exp_range_reduce with a fixed-latency core model
module tb_exp_range_reduce;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        coreRst, coreStart, coreDone;
  logic [15:0] coreX;
  logic [17:0] coreR;
  logic [15:0] cur_f;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          core_cnt = 0;
  bit          core_mute = 1'b0;

  typedef struct { logic [27:0] y; logic err; int t0; int lat; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  exp_range_reduce_if #(.INT_W(3), .FRAC_W(16), .OUT_W(28)) sys ();

  exp_range_reduce dut (
    .clk(clk), .rst(rst), .sys(sys),
    .coreRst(coreRst), .coreStart(coreStart), .coreX(coreX),
    .coreR(coreR), .coreDone(coreDone)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Core model: done pulses six negedges after start is seen; coreR is scrambled once done drops
  always @(negedge clk) begin
    if (coreDone) coreR = coreR ^ 18'h2AAAA;
    if (coreRst) begin
      core_cnt = 0;
      coreDone = 1'b0;
    end else if (coreStart) begin
      chk("coreX_at_launch", {16'h0, coreX}, {16'h0, cur_f});
      core_cnt = 6;
      coreDone = 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      coreDone = (core_cnt == 0) && !core_mute;
    end else begin
      coreDone = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst && sys.done) begin
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_done: done=1 with no pending request, yOut=0x%0h", sys.yOut);
      end else begin
        mon_e = sb.pop_front();
        chk("yOut", {4'h0, sys.yOut}, {4'h0, mon_e.y});
        chk("err", {31'h0, sys.err}, {31'h0, mon_e.err});
        chk("latency", cyc - mon_e.t0, mon_e.lat);
        chk("busy_in_done", {31'h0, sys.busy}, 32'd1);
        @(negedge clk);
        chk("busy_after_done", {31'h0, sys.busy}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!sys.busy) return;
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    chk("done_timeout", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic issue(input logic [18:0] x, input logic [17:0] r, input logic [27:0] y,
                       input logic e_err, input int lat, input bit expect_done);
    exp_t e;
    wait_idle();
    sys.xIn   = x;
    coreR     = r;
    cur_f     = x[15:0];
    sys.start = 1'b1;
    e.y = y; e.err = e_err; e.t0 = cyc; e.lat = lat;
    if (expect_done) sb.push_back(e);
    @(negedge clk);
    sys.start = 1'b0;
    sys.xIn   = ~x;
  endtask

  task automatic run_op(input logic [18:0] x, input logic [17:0] r, input logic [27:0] y);
    issue(x, r, y, 1'b0, 27, 1'b1);
    wait_drain(60);
  endtask

  initial begin
    int c0;
    sys.start = 1'b0;
    sys.xIn   = '0;
    coreR     = '0;
    coreDone  = 1'b0;
    cur_f     = '0;
    #12;
    chk("rst_busy", {31'h0, sys.busy}, 32'd0);
    chk("rst_done", {31'h0, sys.done}, 32'd0);
    chk("rst_yOut", {4'h0, sys.yOut}, 32'd0);
    chk("rst_err", {31'h0, sys.err}, 32'd0);
    chk("rst_coreStart", {31'h0, coreStart}, 32'd0);
    chk("rst_coreX", {16'h0, coreX}, 32'd0);
    chk("rst_coreRst", {31'h0, coreRst}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_coreRst", {31'h0, coreRst}, 32'd0);

    run_op(19'h00000, 18'h10000, 28'd65536);
    run_op(19'h08000, 18'd108051, 28'd108051);
    run_op(19'h0FFFF, 18'd178143, 28'd178143);
    run_op(19'h10000, 18'h10000, 28'd178145);
    run_op(19'h18000, 18'd108051, 28'd293713);
    run_op(19'h20000, 18'h10000, 28'd484249);
    run_op(19'h30000, 18'h10000, 28'd1316326);
    run_op(19'h40000, 18'h10000, 28'd3578144);
    run_op(19'h50000, 18'h10000, 28'd9726405);
    run_op(19'h60000, 18'h10000, 28'd26439109);
    run_op(19'h70000, 18'h10000, 28'd71868951);
    run_op(19'h7FFFF, 18'd178143, 28'd195357522);
    run_op(19'h7FFFF, 18'h3FFFF, 28'hFFFFFFF);

    // start during MUL and in the DONE cycle must both be dropped
    issue(19'h10000, 18'h10000, 28'd178145, 1'b0, 27, 1'b1);
    c0 = cyc - 1;
    for (int k = 0; k < 40 && cyc < c0 + 15; k++) @(negedge clk);
    sys.xIn = 19'h7FFFF; sys.start = 1'b1;
    @(negedge clk);
    sys.start = 1'b0;
    for (int k = 0; k < 40 && cyc < c0 + 27; k++) @(negedge clk);
    sys.start = 1'b1;
    @(negedge clk);
    sys.start = 1'b0;
    repeat (40) @(negedge clk);
    chk("ignored_start_idle", {31'h0, sys.busy}, 32'd0);
    chk("ignored_start_drained", sb.size(), 32'd0);

    // asynchronous abort while waiting on the core
    issue(19'h2ABCD, 18'h10000, 28'd0, 1'b0, 27, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {31'h0, sys.busy}, 32'd0);
    chk("abort_done", {31'h0, sys.done}, 32'd0);
    chk("abort_yOut", {4'h0, sys.yOut}, 32'd0);
    chk("abort_err", {31'h0, sys.err}, 32'd0);
    chk("abort_coreStart", {31'h0, coreStart}, 32'd0);
    chk("abort_coreX", {16'h0, coreX}, 32'd0);
    chk("abort_coreRst", {31'h0, coreRst}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_stays_idle", {31'h0, sys.busy}, 32'd0);
    run_op(19'h08000, 18'd108051, 28'd108051);

`ifdef EXP_RR_TIMEOUT_EN
    core_mute = 1'b1;
    issue(19'h18000, 18'd108051, 28'd0, 1'b1, 258, 1'b1);
    wait_drain(300);
    core_mute = 1'b0;
    run_op(19'h20000, 18'h10000, 28'd484249);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors = errors + 1;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
